// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the lfsr_prng generator: maximal-length
// feedback masks (bit i set = state[i] feeds the XOR) and a parameter legality check.
package lfsr_pkg;

  localparam logic [2:0]  TAPS_3  = 3'h6;
  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [4:0]  TAPS_5  = 5'h14;
  localparam logic [5:0]  TAPS_6  = 6'h30;
  localparam logic [6:0]  TAPS_7  = 7'h60;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [8:0]  TAPS_9  = 9'h110;
  localparam logic [9:0]  TAPS_10 = 10'h240;
  localparam logic [10:0] TAPS_11 = 11'h500;
  localparam logic [11:0] TAPS_12 = 12'h829;
  localparam logic [12:0] TAPS_13 = 13'h100D;
  localparam logic [13:0] TAPS_14 = 14'h2015;
  localparam logic [14:0] TAPS_15 = 15'h6000;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [16:0] TAPS_17 = 17'h12000;
  localparam logic [17:0] TAPS_18 = 18'h20400;
  localparam logic [18:0] TAPS_19 = 19'h40023;
  localparam logic [19:0] TAPS_20 = 20'h90000;
  localparam logic [20:0] TAPS_21 = 21'h140000;
  localparam logic [21:0] TAPS_22 = 22'h300000;
  localparam logic [22:0] TAPS_23 = 23'h420000;
  localparam logic [23:0] TAPS_24 = 24'hE10000;
  localparam logic [24:0] TAPS_25 = 25'h1200000;
  localparam logic [25:0] TAPS_26 = 26'h2000023;
  localparam logic [26:0] TAPS_27 = 27'h4000013;
  localparam logic [27:0] TAPS_28 = 28'h9000000;
  localparam logic [28:0] TAPS_29 = 29'h14000000;
  localparam logic [29:0] TAPS_30 = 30'h20000029;
  localparam logic [30:0] TAPS_31 = 31'h48000000;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  // True when the generator parameters describe a usable, lockup-free LFSR.
  function automatic bit lfsr_params_ok(input int width, input logic [31:0] taps,
                                        input logic [31:0] seed, input int out_bits,
                                        input int thresh_w);
    bit ok;
    ok = (width >= 3) && (width <= 32);
    ok = ok && (out_bits >= 1) && (out_bits <= width);
    ok = ok && (thresh_w >= 1) && (thresh_w <= width);
    ok = ok && (seed != 32'd0);
    if (ok) ok = taps[width-1];
    return ok;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational Fibonacci LFSR step: shift left, XOR of tapped bits enters at bit 0.
module lfsr_step #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(16'hB400)
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next
);

  logic fb;

  assign fb   = ^(state & TAPS);
  assign next = {state[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_prng.sv
// Parametrised multi-bit LFSR PRNG with seed load, zero-seed protection and a
// registered threshold comparator. Define LFSR_PRNG_PERIOD_CHECK_EN to add period measurement.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] INIT_SEED = WIDTH'(16'hACE1),
  parameter int               OUT_BITS  = 1,
  parameter int               THRESH_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed_in,
  input  logic [THRESH_W-1:0] thresh,
  output logic [WIDTH-1:0]    state_o,
  output logic [OUT_BITS-1:0] rand_o,
  output logic                hit_o,
  output logic                zero_seed_o
`ifdef LFSR_PRNG_PERIOD_CHECK_EN
  ,
  output logic [WIDTH-1:0]    period_o,
  output logic                period_vld_o
`endif
);

  if (!lfsr_params_ok(WIDTH, 32'(TAPS), 32'(INIT_SEED), OUT_BITS, THRESH_W)) begin : g_bad_params
    $error("lfsr_prng: illegal WIDTH/TAPS/INIT_SEED/OUT_BITS/THRESH_W combination");
  end

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] chain [0:OUT_BITS];
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_state;

  // OUT_BITS single steps chained so the whole advance settles in one cycle.
  assign chain[0] = state;
  for (genvar gi = 0; gi < OUT_BITS; gi++) begin : g_step
    lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
      .state (chain[gi]),
      .next  (chain[gi+1])
    );
  end

  // A zero seed would lock the register, so it falls back to INIT_SEED.
  assign load_val = (seed_in != '0) ? seed_in : INIT_SEED;

  always_comb begin
    next_state = state;
    if (seed_load)
      next_state = load_val;
    else if (en)
      next_state = chain[OUT_BITS];
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= INIT_SEED;
      hit_o       <= 1'b0;
      zero_seed_o <= 1'b0;
    end else begin
      state <= next_state;
      hit_o <= (next_state[THRESH_W-1:0] < thresh);
      if (seed_load)
        zero_seed_o <= (seed_in == '0);
    end
  end

  assign state_o = state;
  assign rand_o  = state[WIDTH-1 -: OUT_BITS];

`ifdef LFSR_PRNG_PERIOD_CHECK_EN
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] cnt_next;

  assign cnt_next = step_cnt + WIDTH'(OUT_BITS);

  always_ff @(posedge clk) begin
    if (!rst_n || seed_load) begin
      start_val    <= next_state;
      step_cnt     <= '0;
      period_o     <= '0;
      period_vld_o <= 1'b0;
    end else if (en) begin
      if (chain[OUT_BITS] == start_val) begin
        period_o     <= cnt_next;
        period_vld_o <= 1'b1;
        step_cnt     <= '0;
      end else begin
        step_cnt <= cnt_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng: a 16-bit default instance and a 4-bit, 2-bits-per-cycle
// instance share control inputs; a bit-level reference model predicts every cycle.
module tb_lfsr_prng;

  logic        clk = 1'b0;
  logic        rst_n, en, seed_load;
  logic [15:0] seed_in;
  logic [7:0]  thresh;
  logic [3:0]  seed4, thresh4;

  logic [15:0] state_o;
  logic        rand_o, hit_o, zero_seed_o;
  logic [3:0]  state4;
  logic [1:0]  rand4;
  logic        hit4, zero4;
`ifdef LFSR_PRNG_PERIOD_CHECK_EN
  logic [15:0] period_o;
  logic        period_vld_o;
  logic [3:0]  period4;
  logic        period_vld4;
`endif

  always #5 clk = ~clk;

  lfsr_prng dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .thresh(thresh), .state_o(state_o), .rand_o(rand_o), .hit_o(hit_o),
    .zero_seed_o(zero_seed_o)
`ifdef LFSR_PRNG_PERIOD_CHECK_EN
    , .period_o(period_o), .period_vld_o(period_vld_o)
`endif
  );

  lfsr_prng #(.WIDTH(4), .TAPS(4'hC), .INIT_SEED(4'b1010), .OUT_BITS(2), .THRESH_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed4),
    .thresh(thresh4), .state_o(state4), .rand_o(rand4), .hit_o(hit4),
    .zero_seed_o(zero4)
`ifdef LFSR_PRNG_PERIOD_CHECK_EN
    , .period_o(period4), .period_vld_o(period_vld4)
`endif
  );

  typedef struct {
    logic [15:0] st;
    logic        hit;
    logic        zero;
    logic [3:0]  st4;
    logic        hit4;
    logic        zero4;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state (values the registers should hold after the next edge).
  logic [15:0] m_st;
  logic        m_hit, m_zero;
  logic [3:0]  m_st4;
  logic        m_hit4, m_zero4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Generic LFSR rule: parity of the tapped bits shifts in at the bottom.
  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] taps,
                                           input int width, input int n);
    logic [31:0] v, mask;
    mask = (32'd1 << width) - 32'd1;
    v = s;
    for (int k = 0; k < n; k++)
      v = ((v << 1) | 32'($countones(v & taps) % 2)) & mask;
    return v;
  endfunction

  // Drive one cycle of stimulus and push what the DUTs must show after the edge.
  task automatic cycle(input logic r, input logic e, input logic l, input logic [15:0] s,
                       input logic [3:0] s4, input logic [7:0] t, input logic [3:0] t4);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; seed_load = l; seed_in = s; seed4 = s4; thresh = t; thresh4 = t4;
    if (!r) begin
      m_st = 16'hACE1; m_hit = 1'b0; m_zero = 1'b0;
      m_st4 = 4'hA;    m_hit4 = 1'b0; m_zero4 = 1'b0;
    end else begin
      if (l) begin
        m_st  = (s != 0) ? s : 16'hACE1;   m_zero  = (s == 0);
        m_st4 = (s4 != 0) ? s4 : 4'hA;     m_zero4 = (s4 == 0);
      end else if (e) begin
        m_st  = 16'(ref_step(32'(m_st), 32'hB400, 16, 1));
        m_st4 = 4'(ref_step(32'(m_st4), 32'hC, 4, 2));
      end
      m_hit  = (m_st % 256) < t;
      m_hit4 = m_st4 < t4;
    end
    x = '{st: m_st, hit: m_hit, zero: m_zero, st4: m_st4, hit4: m_hit4, zero4: m_zero4};
    exp_q.push_back(x);
  endtask

  // Monitor: every cycle the DUTs present a fresh registered result.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("state", 32'(state_o), 32'(x.st));
        check("rand", 32'(rand_o), 32'(x.st[15]));
        check("hit", 32'(hit_o), 32'(x.hit));
        check("zero_seed", 32'(zero_seed_o), 32'(x.zero));
        check("state4", 32'(state4), 32'(x.st4));
        check("rand4", 32'(rand4), 32'(x.st4[3:2]));
        check("hit4", 32'(hit4), 32'(x.hit4));
        check("zero4", 32'(zero4), 32'(x.zero4));
      end
    end
  end

  initial begin
    int wait_cnt;
    rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed_in = '0; seed4 = '0;
    thresh = '0; thresh4 = '0;
    m_st = '0; m_hit = 0; m_zero = 0; m_st4 = '0; m_hit4 = 0; m_zero4 = 0;

    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 16'h1234, 4'h3, 8'h10, 4'h8);
    #2;
    check("reset_state_const", 32'(state_o), 32'hACE1);
    check("reset_state4_const", 32'(state4), 32'hA);
    check("reset_rand4_const", 32'(rand4), 32'h2);

    // Free-running steps with thresh=0: hit must stay low.
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 0, 8'h00, 4'h0);
    // Load wins over en, then zero seed fallback, then a nonzero load clears the flag.
    cycle(1, 1, 1, 16'h1234, 4'h5, 8'h40, 4'h4);
    cycle(1, 1, 1, 16'h0000, 4'h0, 8'h40, 4'h4);
    cycle(1, 0, 0, 0, 0, 8'h40, 4'h4);
    cycle(1, 1, 1, 16'h0001, 4'h1, 8'h40, 4'h4);
    // Hold with en=0 and constant thresh.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 8'h80, 4'h8);
    // Max threshold: miss only at low byte FF.
    for (int i = 0; i < 40; i++) cycle(1, 1, 0, 0, 0, 8'hFF, 4'hF);
    // Reset in the middle of stepping.
    cycle(0, 1, 0, 0, 0, 8'hFF, 4'hF);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 8'hFF, 4'hF);

    for (int i = 0; i < 3000; i++) begin
      logic r, e, l;
      logic [15:0] s;
      logic [3:0]  s4;
      r  = ($urandom_range(99) != 0);
      e  = ($urandom_range(3) != 0);
      l  = ($urandom_range(19) == 0);
      s  = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
      s4 = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom);
      cycle(r, e, l, s, s4, 8'($urandom), 4'($urandom));
    end

`ifdef LFSR_PRNG_PERIOD_CHECK_EN
    cycle(1, 0, 1, 16'h1234, 4'h3, 8'h80, 4'h8);
    #2;
    check("period_vld_after_load", 32'(period_vld_o), 32'h0);
    wait_cnt = 0;
    while (period_vld_o !== 1'b1 && wait_cnt < 70000) begin
      cycle(1, 1, 0, 0, 0, 8'h80, 4'h8);
      #2;
      wait_cnt++;
    end
    check("period_vld", 32'(period_vld_o), 32'h1);
    check("period", 32'(period_o), 32'd65535);
    check("period_cycles", 32'(wait_cnt), 32'd65535);
`endif

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
